ppe_rr_arbiter: RTL
===================

# ppe_rr_arbiter

Round-robin arbiter built around the programmable priority encoder datapath. It keeps a registered priority pointer and drives the `thermometer` stage with it to mask off requests below the pointer. It picks the lowest-indexed set request at or above the pointer, wrapping to index 0, and presents the winner on a valid/ready grant interface. On each accepted grant the pointer advances to winner+1, modulo WIDTH.

## Interface
- `WIDTH`, 16, number of requesters; must equal 2**LOG_W.
- `LOG_W`, 4, width of index and pointer fields.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  WIDTH  request vector, level-sensitive, sampled every cycle.
- `grant_valid`  out  1  a registered grant is presented.
- `grant_ready`  in  1  consumer accepts the grant; a handshake occurs when valid and ready are both 1.
- `grant_idx`  out  LOG_W  index of the granted requester.
- `grant_onehot`  out  WIDTH  one-hot copy of `grant_idx`; all zero when not valid.
- `ptr_load`  in  1  overwrite the priority pointer.
- `ptr_load_val`  in  LOG_W  new pointer value.
- `ptr`  out  LOG_W  current registered priority pointer.

## Operation
- States: IDLE (no grant held) and GRANT (grant held). `grant_valid` is 1 exactly when the state is GRANT.
- Effective pointer `eptr` is selected in this priority order:
  - `ptr_load_val` when `ptr_load`=1;
  - else `grant_idx`+1 (mod WIDTH) when a handshake occurs this cycle;
  - else `ptr`.
- `ptr` <= `eptr` every cycle.
- Selection:
  - mask = ~thermo(`eptr`), which keeps bits >= `eptr`;
  - m = `req` & mask;
  - winner = lowest set bit of m if m≠0, else lowest set bit of `req`.
- IDLE:
  - `req`≠0 → register the winner into `grant_idx`/`grant_onehot` and go to GRANT.
  - `req`=0 → stay in IDLE.
- GRANT without handshake: `grant_idx`, `grant_onehot` and `grant_valid` hold. Changes on `req` are ignored and a grant is never withdrawn. `ptr_load` still updates `ptr` only.
- GRANT with handshake:
  - `req`≠0 → register a new winner, computed with the post-advance `eptr`, and stay in GRANT. This gives back-to-back grants with no bubble.
  - `req`=0 → go to IDLE and clear `grant_onehot`.
- A requester still asserting in the cycle of its own handshake is eligible again. It wins only if no other request lies between `eptr` and the wrap point.
- Wrap-around: `grant_idx`=WIDTH-1 accepted → `ptr`=0.

## Timing
- Reset state: IDLE, `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0, `ptr`=0.
- Reset takes effect immediately on `rst_n` falling, including mid-grant. An in-flight grant is dropped without a handshake.
- Latency: `req` sampled in cycle N → `grant_valid` high in N+1.
- Throughput: one grant per cycle while `grant_ready`=1 and `req`≠0.
- `ptr_load` in cycle N affects the selection made at the end of cycle N and appears on `ptr` in N+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `ppe_pkg` holds:
  - state localparams: ST_IDLE=1'b0, ST_GRANT=1'b1;
  - default WIDTH/LOG_W;
  - the lowest-set-bit-to-index function, also used by the fixed-priority encoder.
- One sub-module instance: `thermometer` #(WIDTH, LOG_W), with `enc`=`eptr`. The mask is its inverted output.
- The `eptr` mux, the find-first-set logic and the state/grant registers are local.

## Test plan
Bench uses WIDTH=16, LOG_W=4.
- Reset: hold `rst_n`=0 with `req`=16'hFFFF → `grant_valid`=0, `ptr`=0. Release → `grant_valid`=1 with `grant_idx`=0 on the next edge.
- Rotation and wrap: `req`=16'hFFFF with `grant_ready`=1 held → `grant_idx` sequence 0,1,…,15,0,1 on consecutive cycles, with `ptr` wrapping 15→0.
- Masked search and wrap: `ptr_load`=1 with value 10, `req`=16'h0420 → grant 10. Then with `ptr`=11 and `req`=16'h0420 → grant 5. With `req`=16'h0021 and `ptr`=10 → grant 0.
- Backpressure: grant 3 outstanding, `grant_ready`=0 for 5 cycles while `req` goes to 0 → `grant_idx`=3 and `grant_valid`=1 stay stable. Then ready=1 → state returns to IDLE and `grant_onehot`=0.
- Load colliding with handshake: grant 3 accepted in the same cycle as `ptr_load`=1 with value 8, `req`=16'h01F0 → next grant 8, `ptr`=8. After grant 8 is accepted, `ptr`=9.
- Async reset mid-grant: pulse `rst_n` low between edges while grant 7 is outstanding → `grant_valid`, `grant_idx` and `ptr` go to 0 without a clock edge.

Source files
------------

// File: rtl/ppe_pkg.sv
// Shared definitions for the programmable priority encoder blocks:
// state encodings, default sizes and the lowest-set-bit index helper.
package ppe_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LOG_W = 4;

    // Upper bound on requester count the helper below can scan.
    localparam int MAX_W = 256;

    typedef enum logic {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } arb_state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned lsb_index(input logic [MAX_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/thermometer.sv
// Thermometer decode: bit i is set for every i strictly below enc.
module thermometer
    import ppe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOG_W = DEF_LOG_W
) (
    input  logic [LOG_W-1:0] enc,
    output logic [WIDTH-1:0] thermo
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign thermo[i] = (enc > LOG_W'(i));
    end

endmodule

// File: rtl/ppe_rr_arbiter.sv
// Round-robin arbiter: registered priority pointer masks the request vector
// through a thermometer stage; winner is held on a valid/ready grant port.
module ppe_rr_arbiter
    import ppe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOG_W = DEF_LOG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [LOG_W-1:0] grant_idx,
    output logic [WIDTH-1:0] grant_onehot,
    input  logic             ptr_load,
    input  logic [LOG_W-1:0] ptr_load_val,
    output logic [LOG_W-1:0] ptr
);

    arb_state_t       state, state_nxt;
    logic             hs;
    logic [LOG_W-1:0] eptr;
    logic [WIDTH-1:0] thermo;
    logic [WIDTH-1:0] masked;
    logic [LOG_W-1:0] winner;
    logic             load_grant;
    logic             clr_grant;

    assign grant_valid = (state == GRANT);
    assign hs          = grant_valid & grant_ready;

    // A pointer load outranks the post-handshake advance.
    always_comb begin
        eptr = ptr;
        if (ptr_load)
            eptr = ptr_load_val;
        else if (hs)
            eptr = grant_idx + LOG_W'(1);
    end

    thermometer #(
        .WIDTH(WIDTH),
        .LOG_W(LOG_W)
    ) u_thermo (
        .enc   (eptr),
        .thermo(thermo)
    );

    assign masked = req & ~thermo;

    always_comb begin
        if (|masked)
            winner = LOG_W'(lsb_index(MAX_W'(masked)));
        else
            winner = LOG_W'(lsb_index(MAX_W'(req)));
    end

    always_comb begin
        state_nxt  = state;
        load_grant = 1'b0;
        clr_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    load_grant = 1'b1;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (hs) begin
                    if (|req) begin
                        load_grant = 1'b1;
                    end else begin
                        clr_grant = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_idx    <= '0;
            grant_onehot <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= eptr;
            if (load_grant) begin
                grant_idx    <= winner;
                grant_onehot <= WIDTH'(1) << winner;
            end else if (clr_grant) begin
                grant_onehot <= '0;
            end
        end
    end

endmodule
